// File: rtl/product_bcd_display_if.sv
// Product handshake between the upstream multiplier and the BCD display stage.
// The multiplier side (master) offers a 2N-bit product with result_valid and
// holds it until the display stage (slave) raises result_ready.
interface product_bcd_display_if #(
    parameter int N = 4
);
    logic             result_valid;
    logic [2*N-1:0]   result;
    logic             result_ready;

    modport master (
        output result_valid,
        output result,
        input  result_ready
    );

    modport slave (
        input  result_valid,
        input  result,
        output result_ready
    );
endinterface

// File: rtl/product_bcd_display.sv
// Downstream stage of the calculator multiplier: accepts a binary product,
// converts it to packed BCD with a bit-serial double-dabble, and scans the
// result onto a common-anode 7-segment display with leading-zero blanking.
module product_bcd_display #(
    parameter int N           = 4,
    parameter int DIGITS      = 3,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                  clk,
    input  logic                  reset,
    product_bcd_display_if.slave  prod,
    output logic                  busy,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  bcd_valid,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     an
);

    localparam int W     = 2 * N;
    localparam int CNT_W = (W > 1) ? $clog2(W) : 1;
    localparam int DIG_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(W - 1);
    localparam logic [DIG_W-1:0] LAST_DIG  = DIG_W'(DIGITS - 1);
    localparam logic [REF_W-1:0] REF_MAX   = REF_W'(REFRESH_DIV - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_CONV   = 2'd1;
    localparam logic [1:0] S_UPDATE = 2'd2;

    function automatic longint pow10(input int d);
        longint p;
        p = 1;
        for (int i = 0; i < d; i++) begin
            p = p * 10;
        end
        return p;
    endfunction

    localparam longint MAX_PRODUCT = (longint'(1) << W) - 1;

    // The largest product must fit in the BCD digits, and the scan period must be non-zero.
    generate
        if (pow10(DIGITS) <= MAX_PRODUCT) begin : g_capacity_error
            $error("product_bcd_display: DIGITS too small for a %0d-bit product", W);
        end
        if (REFRESH_DIV < 1) begin : g_refresh_error
            $error("product_bcd_display: REFRESH_DIV must be at least 1");
        end
    endgenerate

    // Active-low segment pattern {g..a} for one BCD code; codes above 9 are blank.
    function automatic logic [6:0] segDecode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    logic [1:0]            r_state;
    logic                  r_ready;
    logic [W-1:0]          r_shift;
    logic [4*DIGITS-1:0]   r_scratch;
    logic [CNT_W-1:0]      r_count;
    logic [4*DIGITS-1:0]   r_bcd;
    logic                  r_bcd_valid;

    logic [REF_W-1:0]      r_refresh;
    logic [DIG_W-1:0]      r_digit;
    logic [DIGITS-1:0]     r_an;
    logic [6:0]            r_seg;

    logic [4*DIGITS-1:0]   w_adj;
    logic [4*DIGITS+W-1:0] w_step;
    logic                  w_wrap;
    logic [DIG_W-1:0]      w_digitNext;
    logic [DIGITS-1:0]     w_blank;
    logic [3:0]            w_nibble;
    logic                  w_curBlank;
    logic [6:0]            w_segNext;

    assign prod.result_ready = r_ready;
    assign busy              = ~r_ready;
    assign bcd               = r_bcd;
    assign bcd_valid         = r_bcd_valid;
    assign an                = r_an;
    assign seg               = r_seg;

    // Double-dabble add-3 correction: any scratch digit of 5 or more gets +3 before the shift.
    always_comb begin
        w_adj = r_scratch;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_scratch[4*i +: 4] >= 4'd5) begin
                w_adj[4*i +: 4] = r_scratch[4*i +: 4] + 4'd3;
            end
        end
    end

    // The corrected digits and the remaining binary bits shift left as one register.
    assign w_step = {w_adj, r_shift} << 1;

    // Handshake and conversion sequencing; bcd only changes once a full conversion is done.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_ready     <= 1'b1;
            r_shift     <= '0;
            r_scratch   <= '0;
            r_count     <= '0;
            r_bcd       <= '0;
            r_bcd_valid <= 1'b0;
        end else begin
            r_bcd_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (prod.result_valid && r_ready) begin
                        r_shift   <= prod.result;
                        r_scratch <= '0;
                        r_count   <= '0;
                        r_ready   <= 1'b0;
                        r_state   <= S_CONV;
                    end
                end
                S_CONV: begin
                    r_scratch <= w_step[4*DIGITS+W-1:W];
                    r_shift   <= w_step[W-1:0];
                    r_count   <= r_count + 1'b1;
                    if (r_count == LAST_STEP) begin
                        r_state <= S_UPDATE;
                    end
                end
                S_UPDATE: begin
                    r_bcd       <= r_scratch;
                    r_bcd_valid <= 1'b1;
                    r_ready     <= 1'b1;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // The scan moves to the next digit position whenever the refresh counter wraps.
    always_comb begin
        w_wrap      = (r_refresh == REF_MAX);
        w_digitNext = r_digit;
        if (w_wrap) begin
            w_digitNext = (r_digit == LAST_DIG) ? '0 : r_digit + 1'b1;
        end
    end

    // A non-units position is blank when it and every higher digit are zero.
    generate
        for (genvar g = 0; g < DIGITS; g++) begin : g_blank
            if (g == 0) begin : g_units
                assign w_blank[g] = 1'b0;
            end else begin : g_upper
                assign w_blank[g] = ~|r_bcd[4*DIGITS-1:4*g];
            end
        end
    endgenerate

    // Select the digit that the next scan position will show and build its segments.
    always_comb begin
        w_nibble   = r_bcd[3:0];
        w_curBlank = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (w_digitNext == DIG_W'(i)) begin
                w_nibble   = r_bcd[4*i +: 4];
                w_curBlank = w_blank[i];
            end
        end
        w_segNext = w_curBlank ? 7'h7F : segDecode(w_nibble);
    end

    // Refresh timing and scan position run freely, independent of the conversion.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_refresh <= '0;
            r_digit   <= '0;
        end else begin
            r_refresh <= w_wrap ? '0 : r_refresh + 1'b1;
            r_digit   <= w_digitNext;
        end
    end

    // Anode enable and segments are registered together so they never disagree.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_an  <= ~DIGITS'(1);
            r_seg <= 7'h40;
        end else begin
            r_an  <= ~(DIGITS'(1) << w_digitNext);
            r_seg <= w_segNext;
        end
    end

endmodule
